// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 keyboard frame receiver, scan-code FIFO and ASCII ROM
// Optional feature macro: PS2_PARITY_CHECK_EN (drop frames with bad odd parity)
module ps2_scan_decoder #(
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  input  logic [7:0] rom_addr,
  output logic [7:0] ascii_lo,
  output logic [7:0] ascii_up
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [2:0]         r_ps2_sync;
  logic [3:0]         r_count;
  logic [9:0]         r_shift;
  logic [FIFO_AW-1:0] r_w_ptr;
  logic [FIFO_AW-1:0] r_r_ptr;
  logic               r_overflow;
  logic [7:0]         r_fifo [DEPTH];
  logic [7:0]         r_ascii_lo;
  logic [7:0]         r_ascii_up;

  logic               w_sample;
  logic               w_last_bit;
  logic               w_parity_ok;
  logic               w_frame_ok;
  logic [FIFO_AW-1:0] w_w_next;
  logic               w_full;
  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic [7:0]         w_lo;
  logic [7:0]         w_up;

  // Falling edge of the synchronized PS/2 clock: older flop high, newer flop low.
  assign w_sample   = r_ps2_sync[2] & ~r_ps2_sync[1];
  assign w_last_bit = (r_count == 4'd10);

  // After ten shifts r_shift holds {parity, data[7:0], start}; ps2_data is the stop bit.
`ifdef PS2_PARITY_CHECK_EN
  assign w_parity_ok = ^r_shift[9:1];
`else
  assign w_parity_ok = 1'b1;
`endif

  assign w_frame_ok = ~r_shift[0] & ps2_data & w_parity_ok;
  assign w_w_next   = r_w_ptr + 1'b1;
  assign w_full     = (w_w_next == r_r_ptr);
  assign w_push     = w_sample & w_last_bit & w_frame_ok & ~w_full;
  assign w_drop     = w_sample & w_last_bit & w_frame_ok & w_full;
  assign ready      = (r_w_ptr != r_r_ptr);
  assign w_pop      = ~nextdata_n & ready;
  assign data       = r_fifo[r_r_ptr];
  assign overflow   = r_overflow;
  assign ascii_lo   = r_ascii_lo;
  assign ascii_up   = r_ascii_up;

  // Three-flop synchronizer for the keyboard clock, idle-high out of reset.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_ps2_sync <= 3'b111;
    end else begin
      r_ps2_sync <= {r_ps2_sync[1:0], ps2_clk};
    end
  end

  // Bit collector: shift in LSB-first, wrap the counter after the stop bit.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_count <= 4'd0;
      r_shift <= 10'd0;
    end else if (w_sample) begin
      if (w_last_bit) begin
        r_count <= 4'd0;
      end else begin
        r_count <= r_count + 4'd1;
        r_shift <= {ps2_data, r_shift[9:1]};
      end
    end
  end

  // FIFO pointers and sticky overflow; a drop in the same cycle as a pop leaves overflow set.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_w_ptr    <= '0;
      r_r_ptr    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_w_ptr <= w_w_next;
      if (w_pop) begin
        r_r_ptr    <= r_r_ptr + 1'b1;
        r_overflow <= 1'b0;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // FIFO storage is written without reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_w_ptr] <= r_shift[8:1];
  end

  // Scan-code to ASCII lookup (lowercase and shifted tables share one decode).
  always_comb begin
    w_lo = 8'h00;
    w_up = 8'h00;
    case (rom_addr)
      8'h1C: begin w_lo = 8'h61; w_up = 8'h41; end
      8'h32: begin w_lo = 8'h62; w_up = 8'h42; end
      8'h21: begin w_lo = 8'h63; w_up = 8'h43; end
      8'h23: begin w_lo = 8'h64; w_up = 8'h44; end
      8'h24: begin w_lo = 8'h65; w_up = 8'h45; end
      8'h2B: begin w_lo = 8'h66; w_up = 8'h46; end
      8'h34: begin w_lo = 8'h67; w_up = 8'h47; end
      8'h33: begin w_lo = 8'h68; w_up = 8'h48; end
      8'h43: begin w_lo = 8'h69; w_up = 8'h49; end
      8'h3B: begin w_lo = 8'h6A; w_up = 8'h4A; end
      8'h42: begin w_lo = 8'h6B; w_up = 8'h4B; end
      8'h4B: begin w_lo = 8'h6C; w_up = 8'h4C; end
      8'h3A: begin w_lo = 8'h6D; w_up = 8'h4D; end
      8'h31: begin w_lo = 8'h6E; w_up = 8'h4E; end
      8'h44: begin w_lo = 8'h6F; w_up = 8'h4F; end
      8'h4D: begin w_lo = 8'h70; w_up = 8'h50; end
      8'h15: begin w_lo = 8'h71; w_up = 8'h51; end
      8'h2D: begin w_lo = 8'h72; w_up = 8'h52; end
      8'h1B: begin w_lo = 8'h73; w_up = 8'h53; end
      8'h2C: begin w_lo = 8'h74; w_up = 8'h54; end
      8'h3C: begin w_lo = 8'h75; w_up = 8'h55; end
      8'h2A: begin w_lo = 8'h76; w_up = 8'h56; end
      8'h1D: begin w_lo = 8'h77; w_up = 8'h57; end
      8'h22: begin w_lo = 8'h78; w_up = 8'h58; end
      8'h35: begin w_lo = 8'h79; w_up = 8'h59; end
      8'h1A: begin w_lo = 8'h7A; w_up = 8'h5A; end
      8'h45: begin w_lo = 8'h30; w_up = 8'h30; end
      8'h16: begin w_lo = 8'h31; w_up = 8'h31; end
      8'h1E: begin w_lo = 8'h32; w_up = 8'h32; end
      8'h26: begin w_lo = 8'h33; w_up = 8'h33; end
      8'h25: begin w_lo = 8'h34; w_up = 8'h34; end
      8'h2E: begin w_lo = 8'h35; w_up = 8'h35; end
      8'h36: begin w_lo = 8'h36; w_up = 8'h36; end
      8'h3D: begin w_lo = 8'h37; w_up = 8'h37; end
      8'h3E: begin w_lo = 8'h38; w_up = 8'h38; end
      8'h46: begin w_lo = 8'h39; w_up = 8'h39; end
      8'h29: begin w_lo = 8'h20; w_up = 8'h20; end
      8'h5A: begin w_lo = 8'h0D; w_up = 8'h0D; end
      default: begin w_lo = 8'h00; w_up = 8'h00; end
    endcase
  end

  // Synchronous ROM output register: one cycle from rom_addr to ascii_*.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_ascii_lo <= 8'h00;
      r_ascii_up <= 8'h00;
    end else begin
      r_ascii_lo <= w_lo;
      r_ascii_up <= w_up;
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb/tb_ps2_scan_decoder.sv - randomized self-checking bench for ps2_scan_decoder
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic [7:0] rom_addr = 8'h00;
  logic [7:0] ascii_lo;
  logic [7:0] ascii_up;

  int total = 0;
  int bad = 0;

  // Reference model: FIFO as a queue with capacity 7, sticky overflow flag.
  logic [7:0] mq[$];
  bit         movf = 0;
  localparam int CAP = 7;

  // Ready-high cycle monitor.
  bit mon = 0;
  int ready_cnt = 0;

  // ASCII reference tables expressed as ordered code lists.
  logic [7:0] letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                    8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                    8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};

  ps2_scan_decoder #(.FIFO_AW(3)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow),
    .rom_addr(rom_addr), .ascii_lo(ascii_lo), .ascii_up(ascii_up)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon && ready) ready_cnt++;

  function automatic logic [15:0] ref_ascii(input logic [7:0] a);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == a) return {8'h61 + 8'(i), 8'h41 + 8'(i)};
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == a) return {8'h30 + 8'(i), 8'h30 + 8'(i)};
    if (a == 8'h29) return 16'h2020;
    if (a == 8'h5A) return 16'h0D0D;
    return 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive nbits of a frame; bad_par inverts the odd-parity bit.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      #30 ps2_clk = 1'b0;
      #50 ps2_clk = 1'b1;
      #30;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    bit valid;
    send_bits(b, bad_par, 11);
`ifdef PS2_PARITY_CHECK_EN
    valid = !bad_par;
`else
    valid = 1;
`endif
    if (valid) begin
      if (mq.size() < CAP) mq.push_back(b);
      else movf = 1;
    end
    @(negedge clk);
  endtask

  task automatic pop1();
    @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    if (mq.size() > 0) begin
      void'(mq.pop_front());
      movf = 0;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ready"}, {7'd0, ready}, {7'd0, mq.size() > 0});
    check({tag, "_ovf"}, {7'd0, overflow}, {7'd0, movf});
    if (mq.size() > 0) check({tag, "_data"}, data, mq[0]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    mq.delete();
    movf = 0;
    @(negedge clk);
  endtask

  task automatic rom_check(input logic [7:0] a);
    logic [15:0] e;
    @(negedge clk);
    rom_addr = a;
    @(negedge clk);
    e = ref_ascii(a);
    check("rom_lo", ascii_lo, e[15:8]);
    check("rom_up", ascii_up, e[7:0]);
  endtask

  initial begin
    logic [7:0] rb;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {7'd0, ready}, 8'd0);
    check("rst_ovf", {7'd0, overflow}, 8'd0);
    check("rst_lo", ascii_lo, 8'h00);
    check("rst_up", ascii_up, 8'h00);
    clrn = 1'b0;
    @(negedge clk);

    // Single frame 0x1C
    send_frame(8'h1C, 0);
    check_state("one");
    check("one_data_fixed", data, 8'h1C);

    // ROM directed and random
    rom_check(8'h1C);
    rom_check(8'h16);
    rom_check(8'hF0);
    rom_check(8'h29);
    rom_check(8'h5A);
    rom_check(8'h12);
    for (int i = 0; i < 20; i++) rom_check(8'($urandom_range(0, 255)));

    // Fill past capacity
    do_reset();
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 0);
    check_state("full");
    check("full_ovf_fixed", {7'd0, overflow}, 8'd1);
    for (int i = 1; i <= 7; i++) begin
      check("drain_data", data, 8'(i));
      pop1();
      check_state("drain");
    end
    check("drain_empty", {7'd0, ready}, 8'd0);

    // Wrong parity
    send_frame(8'h1C, 1);
    check_state("badpar");
    while (mq.size() > 0) pop1();

    // Reset mid-frame
    send_bits(8'h55, 0, 5);
    do_reset();
    send_frame(8'h29, 0);
    check_state("midrst");
    check("midrst_data_fixed", data, 8'h29);
    pop1();
    check("midrst_one", {7'd0, ready}, 8'd0);

    // Pop held while a frame lands on an empty FIFO
    @(negedge clk);
    nextdata_n = 1'b0;
    ready_cnt = 0;
    mon = 1;
    send_bits(8'h3A, 0, 11);
    repeat (3) @(negedge clk);
    mon = 0;
    nextdata_n = 1'b1;
    check("hold_pop_cnt", 8'(ready_cnt), 8'd1);
    check("hold_pop_ready", {7'd0, ready}, 8'd0);

    // Randomized frames and pops against the model
    for (int it = 0; it < 30; it++) begin
      rb = 8'($urandom);
      send_frame(rb, $urandom_range(0, 3) == 0);
      check_state("rnd_push");
      for (int p = 0; p < int'($urandom_range(0, 1)); p++) begin
        pop1();
        check_state("rnd_pop");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
